tri_raster_scan: RTL and testbench

- Point generator for the triangle point-in-triangle path. The containment checker consumes a triangle plus a candidate point and returns inside/outside. This block works the other way round: it takes a triangle and transmits every integer point inside it as a stream.
- Scans the triangle's bounding box in row-major order and tests one candidate per cycle with three edge functions. Only inside points are emitted, over a valid/ready stream, followed by a done pulse carrying the point count.

---
 rtl/tri_pkg.sv | 33 +++
 rtl/tri_edge_fn.sv | 44 ++++
 rtl/tri_raster_scan.sv | 241 ++++++++++++++++++++++++
 tb/tb_tri_raster_scan.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tri_pkg.sv
// Shared definitions for the triangle raster scanner.
//   COORD_W_DEF : default unsigned coordinate width.
//   diff_w/prod_w/edge_w : derived signed widths for vertex differences,
//                          partial products and the full edge function.
//   state_e     : scanner FSM states.
package tri_pkg;

    localparam int COORD_W_DEF = 12;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SCAN  = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_e;

    // Difference of two unsigned coordinates needs one extra (sign) bit.
    function automatic int diff_w(input int coord_w);
        return coord_w + 1;
    endfunction

    // Product of two differences.
    function automatic int prod_w(input int coord_w);
        return 2 * coord_w + 2;
    endfunction

    // Difference of two products, kept at full precision.
    function automatic int edge_w(input int coord_w);
        return 2 * coord_w + 3;
    endfunction

endpackage

// File: rtl/tri_edge_fn.sv
// Combinational edge function e(a,b,p) = (bx-ax)*(py-ay) - (by-ay)*(px-ax).
// Sign tells on which side of the directed edge a->b the point p lies;
// zero means p is on the line through a and b.
//   ax,ay,bx,by : edge endpoints (unsigned)
//   px,py       : point under test (unsigned)
//   e           : signed result, full width, never truncated
module tri_edge_fn
    import tri_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic        [COORD_W-1:0]          ax,
    input  logic        [COORD_W-1:0]          ay,
    input  logic        [COORD_W-1:0]          bx,
    input  logic        [COORD_W-1:0]          by,
    input  logic        [COORD_W-1:0]          px,
    input  logic        [COORD_W-1:0]          py,
    output logic signed [edge_w(COORD_W)-1:0]  e
);

    localparam int DIFF_W = diff_w(COORD_W);
    localparam int PROD_W = prod_w(COORD_W);
    localparam int EDGE_W = edge_w(COORD_W);

    logic signed [DIFF_W-1:0] d_bax;
    logic signed [DIFF_W-1:0] d_pay;
    logic signed [DIFF_W-1:0] d_bay;
    logic signed [DIFF_W-1:0] d_pax;
    logic signed [PROD_W-1:0] prod_l;
    logic signed [PROD_W-1:0] prod_r;

    always_comb begin
        // Zero-extend to make the operands non-negative signed values first.
        d_bax  = $signed({1'b0, bx}) - $signed({1'b0, ax});
        d_pay  = $signed({1'b0, py}) - $signed({1'b0, ay});
        d_bay  = $signed({1'b0, by}) - $signed({1'b0, ay});
        d_pax  = $signed({1'b0, px}) - $signed({1'b0, ax});
        // Size casts keep signedness, so these sign-extend before multiplying.
        prod_l = PROD_W'(d_bax) * PROD_W'(d_pay);
        prod_r = PROD_W'(d_bay) * PROD_W'(d_pax);
        e      = EDGE_W'(prod_l) - EDGE_W'(prod_r);
    end

endmodule

// File: rtl/tri_raster_scan.sv
// Triangle raster scanner: accepts a triangle and streams every integer
// point inside it (edges and vertices included), scanning the bounding box
// row-major, one candidate per cycle, then pulses done with the point count.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : triangle descriptor handshake (ready only when idle)
//   p1x..p3y            : triangle vertices, latched on accept
//   pt_valid/pt_ready   : point stream handshake
//   pt_x, pt_y          : emitted point, stable while stalled
//   done                : one-cycle pulse at end of scan
//   count               : points emitted; held until the next accept
module tri_raster_scan
    import tri_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int CNT_W   = 2 * COORD_W + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] p1x,
    input  logic [COORD_W-1:0] p1y,
    input  logic [COORD_W-1:0] p2x,
    input  logic [COORD_W-1:0] p2y,
    input  logic [COORD_W-1:0] p3x,
    input  logic [COORD_W-1:0] p3y,
    output logic               pt_valid,
    input  logic               pt_ready,
    output logic [COORD_W-1:0] pt_x,
    output logic [COORD_W-1:0] pt_y,
    output logic               done,
    output logic [CNT_W-1:0]   count
);

    localparam int EDGE_W = edge_w(COORD_W);

    typedef logic [COORD_W-1:0] coord_t;

    state_e                     state_q, state_d;
    logic [2:0][COORD_W-1:0]    vx_q, vx_d;
    logic [2:0][COORD_W-1:0]    vy_q, vy_d;
    coord_t                     xmin_q, xmin_d;
    coord_t                     xmax_q, xmax_d;
    coord_t                     ymin_q, ymin_d;
    coord_t                     ymax_q, ymax_d;
    logic signed [EDGE_W-1:0]   area2_q, area2_d;
    coord_t                     cx_q, cx_d;
    coord_t                     cy_q, cy_d;
    coord_t                     pt_x_q, pt_x_d;
    coord_t                     pt_y_q, pt_y_d;
    logic                       pt_valid_q, pt_valid_d;
    logic [CNT_W-1:0]           count_q, count_d;

    // Combinational helpers
    logic signed [EDGE_W-1:0]   area2_c;
    logic signed [EDGE_W-1:0]   edge_val [3];
    logic [2:0]                 edge_ge;
    logic [2:0]                 edge_le;
    logic                       cand_inside;
    logic                       last_cand;
    coord_t                     adv_x;
    coord_t                     adv_y;
    coord_t                     bb_xmin, bb_xmax, bb_ymin, bb_ymax;

    function automatic coord_t min3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic coord_t max3(input coord_t a, input coord_t b, input coord_t c);
        coord_t m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Twice the signed area, from the latched vertices (used in SETUP).
    tri_edge_fn #(.COORD_W(COORD_W)) u_area (
        .ax (vx_q[0]), .ay (vy_q[0]),
        .bx (vx_q[1]), .by (vy_q[1]),
        .px (vx_q[2]), .py (vy_q[2]),
        .e  (area2_c)
    );

    // Edge k runs from vertex k to vertex k+1 (mod 3): p1->p2, p2->p3, p3->p1.
    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
        localparam int NI = (gi + 1) % 3;

        tri_edge_fn #(.COORD_W(COORD_W)) u_edge (
            .ax (vx_q[gi]), .ay (vy_q[gi]),
            .bx (vx_q[NI]), .by (vy_q[NI]),
            .px (cx_q),     .py (cy_q),
            .e  (edge_val[gi])
        );

        assign edge_ge[gi] = ~edge_val[gi][EDGE_W-1];
        assign edge_le[gi] = edge_val[gi][EDGE_W-1] | (edge_val[gi] == '0);
    end

    // Inclusive test: points on an edge give zero and count as inside.
    // The area sign selects the test so winding order does not matter.
    assign cand_inside = (area2_q != '0) &&
                         (area2_q[EDGE_W-1] ? (&edge_le) : (&edge_ge));

    assign bb_xmin = min3(vx_q[0], vx_q[1], vx_q[2]);
    assign bb_xmax = max3(vx_q[0], vx_q[1], vx_q[2]);
    assign bb_ymin = min3(vy_q[0], vy_q[1], vy_q[2]);
    assign bb_ymax = max3(vy_q[0], vy_q[1], vy_q[2]);

    // Cursor step. Comparing against the max before incrementing keeps the
    // cursor from wrapping when the box touches 2^COORD_W-1.
    assign last_cand = (cx_q == xmax_q) && (cy_q == ymax_q);

    always_comb begin
        if (cx_q == xmax_q) begin
            adv_x = xmin_q;
            adv_y = cy_q + coord_t'(1);
        end else begin
            adv_x = cx_q + coord_t'(1);
            adv_y = cy_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        vx_d       = vx_q;
        vy_d       = vy_q;
        xmin_d     = xmin_q;
        xmax_d     = xmax_q;
        ymin_d     = ymin_q;
        ymax_d     = ymax_q;
        area2_d    = area2_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        pt_x_d     = pt_x_q;
        pt_y_d     = pt_y_q;
        pt_valid_d = pt_valid_q;
        count_d    = count_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    vx_d    = {p3x, p2x, p1x};
                    vy_d    = {p3y, p2y, p1y};
                    count_d = '0;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                xmin_d  = bb_xmin;
                xmax_d  = bb_xmax;
                ymin_d  = bb_ymin;
                ymax_d  = bb_ymax;
                area2_d = area2_c;
                cx_d    = bb_xmin;
                cy_d    = bb_ymin;
                state_d = (area2_c == '0) ? DONE : SCAN;
            end

            SCAN: begin
                if (cand_inside) begin
                    // Cursor stays put; it advances once the point is taken.
                    pt_x_d     = cx_q;
                    pt_y_d     = cy_q;
                    pt_valid_d = 1'b1;
                    state_d    = EMIT;
                end else if (last_cand) begin
                    state_d = DONE;
                end else begin
                    cx_d = adv_x;
                    cy_d = adv_y;
                end
            end

            EMIT: begin
                if (pt_valid_q && pt_ready) begin
                    count_d    = count_q + CNT_W'(1);
                    pt_valid_d = 1'b0;
                    if (last_cand) begin
                        state_d = DONE;
                    end else begin
                        cx_d    = adv_x;
                        cy_d    = adv_y;
                        state_d = SCAN;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vx_q       <= '0;
            vy_q       <= '0;
            xmin_q     <= '0;
            xmax_q     <= '0;
            ymin_q     <= '0;
            ymax_q     <= '0;
            area2_q    <= '0;
            cx_q       <= '0;
            cy_q       <= '0;
            pt_x_q     <= '0;
            pt_y_q     <= '0;
            pt_valid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            vx_q       <= vx_d;
            vy_q       <= vy_d;
            xmin_q     <= xmin_d;
            xmax_q     <= xmax_d;
            ymin_q     <= ymin_d;
            ymax_q     <= ymax_d;
            area2_q    <= area2_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            pt_x_q     <= pt_x_d;
            pt_y_q     <= pt_y_d;
            pt_valid_q <= pt_valid_d;
            count_q    <= count_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign done     = (state_q == DONE);
    assign pt_valid = pt_valid_q;
    assign pt_x     = pt_x_q;
    assign pt_y     = pt_y_q;
    assign count    = count_q;

endmodule

// File: tb/tb_tri_raster_scan.sv
module tb_tri_raster_scan;

    localparam int W  = 12;
    localparam int WS = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          in_valid;
    logic          sel;       // 0: 12-bit instance, 1: 4-bit instance
    logic          pt_ready;
    logic [W-1:0]  p1x, p1y, p2x, p2y, p3x, p3y;

    logic            a_in_ready, a_pt_valid, a_done;
    logic [W-1:0]    a_pt_x, a_pt_y;
    logic [2*W:0]    a_count;
    logic            b_in_ready, b_pt_valid, b_done;
    logic [WS-1:0]   b_pt_x, b_pt_y;
    logic [2*WS:0]   b_count;

    tri_raster_scan #(.COORD_W(W)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid && !sel),
        .in_ready (a_in_ready),
        .p1x      (p1x), .p1y (p1y),
        .p2x      (p2x), .p2y (p2y),
        .p3x      (p3x), .p3y (p3y),
        .pt_valid (a_pt_valid),
        .pt_ready (pt_ready),
        .pt_x     (a_pt_x),
        .pt_y     (a_pt_y),
        .done     (a_done),
        .count    (a_count)
    );

    // Small instance so the full-range corner triangle fits in a short run.
    tri_raster_scan #(.COORD_W(WS)) u_small (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid && sel),
        .in_ready (b_in_ready),
        .p1x      (p1x[WS-1:0]), .p1y (p1y[WS-1:0]),
        .p2x      (p2x[WS-1:0]), .p2y (p2y[WS-1:0]),
        .p3x      (p3x[WS-1:0]), .p3y (p3y[WS-1:0]),
        .pt_valid (b_pt_valid),
        .pt_ready (pt_ready),
        .pt_x     (b_pt_x),
        .pt_y     (b_pt_y),
        .done     (b_done),
        .count    (b_count)
    );

    logic          m_in_ready, m_pt_valid, m_done;
    logic [W-1:0]  m_x, m_y;
    logic [2*W:0]  m_count;

    assign m_in_ready = sel ? b_in_ready : a_in_ready;
    assign m_pt_valid = sel ? b_pt_valid : a_pt_valid;
    assign m_done     = sel ? b_done     : a_done;
    assign m_x        = sel ? {{(W-WS){1'b0}}, b_pt_x} : a_pt_x;
    assign m_y        = sel ? {{(W-WS){1'b0}}, b_pt_y} : a_pt_y;
    assign m_count    = sel ? {{(2*W-2*WS){1'b0}}, b_count} : a_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    int exp_q[$];
    int exp_total = 0;

    // Observations
    int n_rx = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
    int first_valid_cyc = 0, first_x = 0, first_y = 0, last_x = 0, last_y = 0;
    bit seen_valid = 0;
    bit hold_prev = 0;
    int prev_x = 0, prev_y = 0;
    int rdy_mode = 0;
    int stall_cnt = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic longint edge_fn(input int ax, input int ay, input int bx,
                                       input int by, input int px, input int py);
        return longint'(bx - ax) * longint'(py - ay) - longint'(by - ay) * longint'(px - ax);
    endfunction

    function automatic int imin3(input int a, input int b, input int c);
        int m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic int imax3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Expected stream: every lattice point of the bounding box, row-major,
    // whose three edge values share the sign of the area (zero allowed).
    function automatic void build_model(input int x1, input int y1, input int x2,
                                        input int y2, input int x3, input int y3);
        longint area, e1, e2, e3;
        exp_q.delete();
        area = edge_fn(x1, y1, x2, y2, x3, y3);
        if (area != 0) begin
            for (int y = imin3(y1, y2, y3); y <= imax3(y1, y2, y3); y++) begin
                for (int x = imin3(x1, x2, x3); x <= imax3(x1, x2, x3); x++) begin
                    e1 = edge_fn(x1, y1, x2, y2, x, y);
                    e2 = edge_fn(x2, y2, x3, y3, x, y);
                    e3 = edge_fn(x3, y3, x1, y1, x, y);
                    if ((area > 0 && e1 >= 0 && e2 >= 0 && e3 >= 0) ||
                        (area < 0 && e1 <= 0 && e2 <= 0 && e3 <= 0))
                        exp_q.push_back(x * 65536 + y);
                end
            end
        end
        exp_total = exp_q.size();
    endfunction

    // Compare process: sampled on the falling edge, so valid&&ready here
    // means a transfer on the next rising edge.
    always @(negedge clk) begin
        int e;
        if (rst_n) begin
            if (hold_prev) begin
                check("stall_hold_valid", m_pt_valid, 1);
                check("stall_hold_x", m_x, prev_x);
                check("stall_hold_y", m_y, prev_y);
            end
            if (m_pt_valid && !seen_valid) begin
                seen_valid      = 1;
                first_valid_cyc = cyc;
            end
            if (m_pt_valid && pt_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_point_x", m_x, -1);
                end else begin
                    e = exp_q.pop_front();
                    check("pt_x", m_x, e / 65536);
                    check("pt_y", m_y, e % 65536);
                end
                if (n_rx == 0) begin
                    first_x = m_x;
                    first_y = m_y;
                end
                last_x = m_x;
                last_y = m_y;
                n_rx++;
            end
            if (m_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("count_at_done", m_count, exp_total);
                check("missing_points", exp_q.size(), 0);
            end
            hold_prev = m_pt_valid && !pt_ready;
            prev_x    = m_x;
            prev_y    = m_y;
        end else begin
            hold_prev = 0;
        end
    end

    // Downstream ready generator.
    initial begin
        pt_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin
                    if (m_pt_valid && m_x == 3 && m_y == 24 && stall_cnt < 5) begin
                        pt_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        pt_ready = 1'b1;
                    end
                end
                2:       pt_ready = ($urandom_range(0, 9) < 7);
                3:       pt_ready = (n_rx < 2);
                default: pt_ready = 1'b1;
            endcase
        end
    end

    task automatic start_tri(input int x1, input int y1, input int x2,
                             input int y2, input int x3, input int y3);
        n_rx       = 0;
        seen_valid = 0;
        stall_cnt  = 0;
        for (int k = 0; k < 50 && !m_in_ready; k++) begin
            @(posedge clk);
            #1;
        end
        check("in_ready_before_start", m_in_ready, 1);
        @(posedge clk);
        #1;
        p1x = W'(x1); p1y = W'(y1);
        p2x = W'(x2); p2y = W'(y2);
        p3x = W'(x3); p3y = W'(y3);
        in_valid = 1'b1;
        @(posedge clk);       // accept edge
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic run_tri(input string tag, input int x1, input int y1, input int x2,
                           input int y2, input int x3, input int y3,
                           input int mode, input bit busy, input int exp_n);
        int d0;
        build_model(x1, y1, x2, y2, x3, y3);
        check({tag, "_model_count"}, exp_total, exp_n);
        rdy_mode = mode;
        d0 = done_cnt;
        start_tri(x1, y1, x2, y2, x3, y3);
        if (busy) begin
            repeat (3) @(posedge clk);
            #1;
            check({tag, "_busy_in_ready"}, m_in_ready, 0);
            p1x = 0; p1y = 0; p2x = 100; p2y = 0; p3x = 0; p3y = 100;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        for (int k = 0; k < 5000 && done_cnt == d0; k++) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_done_seen"}, done_cnt - d0, 1);
        check({tag, "_count_held"}, m_count, exp_n);
        check({tag, "_points_rx"}, n_rx, exp_n);
        $display("triangle %s: (%0d,%0d) (%0d,%0d) (%0d,%0d) points=%0d count=%0d",
                 tag, x1, y1, x2, y2, x3, y3, n_rx, m_count);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int d0;
        rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0;
        p1x = 0; p1y = 0; p2x = 0; p2y = 0; p3x = 0; p3y = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_pt_valid", a_pt_valid, 0);
        check("rst_pt_x", a_pt_x, 0);
        check("rst_pt_y", a_pt_y, 0);
        check("rst_done", a_done, 0);
        check("rst_count", a_count, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Pin the model against hand-derived values for the base triangle.
        build_model(2, 23, 1, 25, 6, 25);
        check("model_first", exp_q[0], 2 * 65536 + 23);
        check("model_second", exp_q[1], 2 * 65536 + 24);
        check("model_last", exp_q[exp_q.size() - 1], 6 * 65536 + 25);
        check("model_no_5_23", int'(exp_q.size() > 0 && exp_q[1] == 5 * 65536 + 23), 0);

        // Base triangle with a 5-cycle stall on (3,24) and a busy pulse.
        run_tri("base", 2, 23, 1, 25, 6, 25, 1, 1, 10);
        check("base_stall_cycles", stall_cnt, 5);
        check("base_first_x", first_x, 2);
        check("base_first_y", first_y, 23);

        // Reverse winding: same set, same order.
        run_tri("reverse", 6, 25, 1, 25, 2, 23, 0, 0, 10);
        check("reverse_last_x", last_x, 6);
        check("reverse_last_y", last_y, 25);

        // Degenerate triangles: done in the cycle after SETUP, no points.
        run_tri("collinear", 0, 0, 5, 5, 10, 10, 0, 0, 0);
        check("collinear_done_latency", done_cyc - acc_cyc, 1);
        check("collinear_no_valid", seen_valid, 0);
        run_tri("point", 7, 7, 7, 7, 7, 7, 0, 0, 0);
        check("point_done_latency", done_cyc - acc_cyc, 1);
        check("point_no_valid", seen_valid, 0);

        // Corner at the top of the 12-bit range; first candidate is inside.
        run_tri("corner", 4093, 4093, 4095, 4093, 4095, 4095, 0, 0, 6);
        check("corner_first_latency", first_valid_cyc - acc_cyc, 2);
        check("corner_last_x", last_x, 4095);
        check("corner_last_y", last_y, 4095);

        // Reset while a point is stalled in the output register.
        build_model(2, 23, 1, 25, 6, 25);
        rdy_mode = 3;
        start_tri(2, 23, 1, 25, 6, 25);
        for (int k = 0; k < 200 && !(m_pt_valid && m_count == 2); k++) begin
            @(posedge clk);
            #3;
        end
        check("pre_reset_valid", m_pt_valid, 1);
        check("pre_reset_count", m_count, 2);
        rst_n = 1'b0;
        #1;
        check("midrst_pt_valid", a_pt_valid, 0);
        check("midrst_in_ready", a_in_ready, 1);
        check("midrst_count", a_count, 0);
        check("midrst_done", a_done, 0);
        exp_q.delete();
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        rdy_mode = 0;
        repeat (6) @(posedge clk);
        #1;
        check("no_done_after_reset", done_cnt - d0, 0);

        // Fresh triangle after reset.
        run_tri("after_reset", 2, 23, 1, 25, 6, 25, 0, 0, 10);

        // Full-range right triangle on the 4-bit instance, random backpressure:
        // x+y<=15 gives 16*17/2 = 136 points.
        sel = 1'b1;
        run_tri("extreme", 0, 0, 15, 0, 0, 15, 2, 0, 136);
        check("extreme_first_x", first_x, 0);
        check("extreme_first_y", first_y, 0);
        check("extreme_last_x", last_x, 0);
        check("extreme_last_y", last_y, 15);
        sel = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
